// File: rtl/instr_buf_pkg.sv
// Shared types and constants for the instruction line buffer.
// Address split: [XLEN-1 : 2+IDX_W] line tag, [2 +: IDX_W] word index, [1:0] ignored.
package instr_buf_pkg;

    typedef enum logic [1:0] {
        IDLE,
        FILL,
        DRAIN
    } fill_state_e;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    function automatic int unsigned idx_width(input int unsigned line_words);
        return $clog2(line_words);
    endfunction

    function automatic int unsigned tag_width(input int unsigned xlen, input int unsigned line_words);
        return xlen - 2 - $clog2(line_words);
    endfunction

    localparam int unsigned DEF_IDX_W = idx_width(4);
    localparam int unsigned DEF_TAG_W = tag_width(32, 4);

endpackage

// File: rtl/instr_fill_fsm.sv
// Line-fill sequencer: issues critical-word-first wrapping beats and
// handles redirect/flush while a beat is outstanding.
module instr_fill_fsm
    import instr_buf_pkg::*;
#(
    parameter int unsigned XLEN       = 32,
    parameter int unsigned LINE_WORDS = 4,
    localparam int unsigned IDX_W     = idx_width(LINE_WORDS),
    localparam int unsigned TAG_W     = tag_width(XLEN, LINE_WORDS)
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             miss_i,
    input  logic             redirect_i,
    input  logic             flush_i,
    input  logic [IDX_W-1:0] pc_idx_i,
    input  logic [TAG_W-1:0] line_tag_i,
    input  logic             mem_ack_i,
    output logic             start_fill_o,
    output logic             beat_wr_o,
    output logic [IDX_W-1:0] beat_idx_o,
    output logic             mem_req_o,
    output logic [XLEN-1:0]  mem_addr_o
);

    fill_state_e      state_q, state_d;
    logic [IDX_W-1:0] start_q, start_d;
    logic [IDX_W-1:0] cnt_q, cnt_d;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            start_q <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            start_q <= start_d;
            cnt_q   <= cnt_d;
        end
    end

    // Line tag only changes on start_fill, so the address is stable for a whole beat.
    assign beat_idx_o = start_q + cnt_q;
    assign mem_req_o  = (state_q != IDLE);
    assign mem_addr_o = mem_req_o ? {line_tag_i, beat_idx_o, 2'b00} : '0;

    always_comb begin
        state_d      = state_q;
        start_d      = start_q;
        cnt_d        = cnt_q;
        start_fill_o = 1'b0;
        beat_wr_o    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (miss_i && !flush_i) begin
                    start_fill_o = 1'b1;
                    start_d      = pc_idx_i;
                    cnt_d        = '0;
                    state_d      = FILL;
                end
            end
            FILL: begin
                if (mem_ack_i) begin
                    if (flush_i) begin
                        state_d = IDLE;
                    end else if (redirect_i) begin
                        // Beat is consumed but belongs to the abandoned line; refill at once.
                        start_fill_o = 1'b1;
                        start_d      = pc_idx_i;
                        cnt_d        = '0;
                    end else begin
                        beat_wr_o = 1'b1;
                        cnt_d     = cnt_q + 1'b1;
                        if (&cnt_q) begin
                            state_d = IDLE;
                        end
                    end
                end else if (flush_i || redirect_i) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (mem_ack_i) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: rtl/instr_line_buffer.sv
// Single-line instruction buffer answering the core's fetch port; misses
// are filled from backing memory through instr_fill_fsm.
module instr_line_buffer
    import instr_buf_pkg::*;
#(
    parameter int unsigned          XLEN       = 32,
    parameter int unsigned          WORD_SIZE  = 32,
    parameter int unsigned          LINE_WORDS = 4,
    parameter logic [WORD_SIZE-1:0] NOP_INSTR  = WORD_SIZE'(instr_buf_pkg::NOP_INSTR)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [XLEN-1:0]      External_PC,
    output logic [WORD_SIZE-1:0] External_Instr,
    output logic                 InstrStall,
    input  logic                 Flush,
    output logic                 Mem_Req,
    output logic [XLEN-1:0]      Mem_Addr,
    input  logic                 Mem_Ack,
    input  logic [WORD_SIZE-1:0] Mem_RData
);

    localparam int unsigned IDX_W = idx_width(LINE_WORDS);
    localparam int unsigned TAG_W = tag_width(XLEN, LINE_WORDS);

    logic [TAG_W-1:0]      line_tag_q, line_tag_d;
    logic [LINE_WORDS-1:0] valid_q, valid_d;
    logic [WORD_SIZE-1:0]  data_q [LINE_WORDS];

    logic [TAG_W-1:0] pc_tag;
    logic [IDX_W-1:0] pc_idx;
    logic             tag_match;
    logic             present;
    logic             hit;
    logic             start_fill;
    logic             beat_wr;
    logic [IDX_W-1:0] beat_idx;
    logic             unused_pc_lo;

    assign pc_tag       = External_PC[XLEN-1 -: TAG_W];
    assign pc_idx       = External_PC[2 +: IDX_W];
    assign unused_pc_lo = ^External_PC[1:0];

    assign tag_match = (pc_tag == line_tag_q);
    assign present   = tag_match && valid_q[pc_idx];
    assign hit       = present && !Flush;

    assign External_Instr = hit ? data_q[pc_idx] : NOP_INSTR;
    assign InstrStall     = !hit;

    instr_fill_fsm #(
        .XLEN       (XLEN),
        .LINE_WORDS (LINE_WORDS)
    ) u_fill_fsm (
        .clk_i        (clk),
        .rst_ni       (reset),
        .miss_i       (!present),
        .redirect_i   (!tag_match),
        .flush_i      (Flush),
        .pc_idx_i     (pc_idx),
        .line_tag_i   (line_tag_q),
        .mem_ack_i    (Mem_Ack),
        .start_fill_o (start_fill),
        .beat_wr_o    (beat_wr),
        .beat_idx_o   (beat_idx),
        .mem_req_o    (Mem_Req),
        .mem_addr_o   (Mem_Addr)
    );

    always_comb begin
        line_tag_d = line_tag_q;
        valid_d    = valid_q;
        if (start_fill) begin
            line_tag_d = pc_tag;
            valid_d    = '0;
        end else begin
            if (Flush) begin
                valid_d = '0;
            end
            if (beat_wr) begin
                valid_d[beat_idx] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            line_tag_q <= '0;
            valid_q    <= '0;
        end else begin
            line_tag_q <= line_tag_d;
            valid_q    <= valid_d;
        end
    end

    always_ff @(posedge clk) begin
        if (beat_wr) begin
            data_q[beat_idx] <= Mem_RData;
        end
    end

endmodule

// File: tb/tb_instr_line_buffer.sv
// Directed bench for instr_line_buffer with a wait-state memory responder
// and a scoreboard of expected beat addresses.
module tb_instr_line_buffer;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] External_PC;
    logic [31:0] External_Instr;
    logic        InstrStall;
    logic        Flush;
    logic        Mem_Req;
    logic [31:0] Mem_Addr;
    logic        Mem_Ack;
    logic [31:0] Mem_RData;

    always #5 clk = ~clk;

    instr_line_buffer #(
        .XLEN       (32),
        .WORD_SIZE  (32),
        .LINE_WORDS (4),
        .NOP_INSTR  (32'h0000_0013)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .External_PC    (External_PC),
        .External_Instr (External_Instr),
        .InstrStall     (InstrStall),
        .Flush          (Flush),
        .Mem_Req        (Mem_Req),
        .Mem_Addr       (Mem_Addr),
        .Mem_Ack        (Mem_Ack),
        .Mem_RData      (Mem_RData)
    );

    localparam logic [31:0] NOP = 32'h0000_0013;

    int unsigned n_tests       = 0;
    int unsigned n_fail        = 0;
    int unsigned mem_wait      = 0;
    int unsigned hs_violations = 0;
    logic [7:0]  gen           = 8'h11;
    logic [31:0] exp_addr_q[$];

    function automatic logic [31:0] memval(input logic [31:0] a);
        return {gen, 8'hA5, a[15:0]};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Memory responder: acks after mem_wait idle cycles, checks beat order and handshake stability.
    initial begin
        logic [31:0] pend_addr;
        logic        pend;
        int unsigned cnt;
        Mem_Ack   = 1'b0;
        Mem_RData = '0;
        pend      = 1'b0;
        pend_addr = '0;
        cnt       = 0;
        forever begin
            @(negedge clk);
            Mem_Ack = 1'b0;
            if (reset !== 1'b1) begin
                pend = 1'b0;
                cnt  = 0;
            end else if (Mem_Req === 1'b1) begin
                if (pend && Mem_Addr !== pend_addr) hs_violations++;
                if (cnt >= mem_wait) begin
                    Mem_Ack   = 1'b1;
                    Mem_RData = memval(Mem_Addr);
                    cnt       = 0;
                    pend      = 1'b0;
                    n_tests++;
                    assert (exp_addr_q.size() != 0) else begin
                        n_fail++;
                        $error("FAIL beat_unexpected: observed addr %h expected no beat", Mem_Addr);
                    end
                    if (exp_addr_q.size() != 0) check("beat_addr", Mem_Addr, exp_addr_q.pop_front());
                end else begin
                    cnt++;
                    pend      = 1'b1;
                    pend_addr = Mem_Addr;
                end
            end else if (pend) begin
                hs_violations++;
                pend = 1'b0;
                cnt  = 0;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic wait_hit(input string tag, input int unsigned maxc);
        int unsigned used = 0;
        while (InstrStall !== 1'b0 && used < maxc) begin
            step();
            used++;
        end
        check({tag, "_hit"}, {31'b0, InstrStall}, 32'd0);
    endtask

    task automatic wait_idle(input string tag, input int unsigned maxc);
        int unsigned used = 0;
        while (Mem_Req !== 1'b0 && used < maxc) begin
            step();
            used++;
        end
        check({tag, "_idle"}, {31'b0, Mem_Req}, 32'd0);
    endtask

    initial begin
        int unsigned n;
        reset       = 1'b0;
        External_PC = 32'h0000_0008;
        Flush       = 1'b0;

        // Reset state and cold critical-word-first miss.
        step();
        check("rst_stall", {31'b0, InstrStall}, 32'd1);
        check("rst_instr", External_Instr, NOP);
        check("rst_req", {31'b0, Mem_Req}, 32'd0);
        check("rst_addr", Mem_Addr, 32'd0);
        exp_addr_q.push_back(32'h08);
        exp_addr_q.push_back(32'h0C);
        exp_addr_q.push_back(32'h00);
        exp_addr_q.push_back(32'h04);
        reset = 1'b1;
        step();
        check("t1_stall_pre", {31'b0, InstrStall}, 32'd1);
        check("t1_req", {31'b0, Mem_Req}, 32'd1);
        check("t1_addr", Mem_Addr, 32'h08);
        step();
        check("t1_stall_rel", {31'b0, InstrStall}, 32'd0);
        check("t1_instr8", External_Instr, memval(32'h08));
        External_PC = 32'h0000_000C;
        #1;
        check("t1_stallC", {31'b0, InstrStall}, 32'd1);
        step();
        check("t1_hitC", {31'b0, InstrStall}, 32'd0);
        check("t1_instrC", External_Instr, memval(32'h0C));
        wait_idle("t1", 20);
        External_PC = 32'h0;
        #1;
        check("t1_instr0", External_Instr, memval(32'h00));
        External_PC = 32'h4;
        #1;
        check("t1_instr4", External_Instr, memval(32'h04));
        check("t1_q_empty", exp_addr_q.size(), 32'd0);

        // Hit-under-fill with 3-cycle memory wait.
        mem_wait = 3;
        step();
        External_PC = 32'h0;
        Flush       = 1'b1;
        #1;
        check("t2_flush_stall", {31'b0, InstrStall}, 32'd1);
        check("t2_flush_instr", External_Instr, NOP);
        exp_addr_q.push_back(32'h00);
        exp_addr_q.push_back(32'h04);
        exp_addr_q.push_back(32'h08);
        exp_addr_q.push_back(32'h0C);
        step();
        check("t2_idle_flush_noreq", {31'b0, Mem_Req}, 32'd0);
        Flush = 1'b0;
        wait_hit("t2_w0", 20);
        check("t2_instr0", External_Instr, memval(32'h00));
        External_PC = 32'h4;
        #1;
        check("t2_stall4", {31'b0, InstrStall}, 32'd1);
        n = 0;
        while (InstrStall !== 1'b0 && n < 12) begin
            step();
            n++;
        end
        check("t2_w1_latency", n, 32'd4);
        check("t2_instr4", External_Instr, memval(32'h04));
        wait_idle("t2", 30);
        check("t2_q_empty", exp_addr_q.size(), 32'd0);

        // Redirect with an outstanding beat.
        step();
        External_PC = 32'h0;
        Flush       = 1'b1;
        exp_addr_q.push_back(32'h00);
        exp_addr_q.push_back(32'h04);
        step();
        Flush = 1'b0;
        wait_hit("t3_w0", 20);
        check("t3_instr0", External_Instr, memval(32'h00));
        External_PC = 32'h100;
        exp_addr_q.push_back(32'h100);
        exp_addr_q.push_back(32'h104);
        exp_addr_q.push_back(32'h108);
        exp_addr_q.push_back(32'h10C);
        #1;
        check("t3_stall_redir", {31'b0, InstrStall}, 32'd1);
        step();
        check("t3_drain_req", {31'b0, Mem_Req}, 32'd1);
        check("t3_drain_addr", Mem_Addr, 32'h04);
        step();
        check("t3_drain_addr2", Mem_Addr, 32'h04);
        wait_hit("t3_new", 30);
        check("t3_instr100", External_Instr, memval(32'h100));
        wait_idle("t3_new", 30);
        External_PC = 32'h4;
        exp_addr_q.push_back(32'h04);
        exp_addr_q.push_back(32'h08);
        exp_addr_q.push_back(32'h0C);
        exp_addr_q.push_back(32'h00);
        #1;
        check("t3_miss4", {31'b0, InstrStall}, 32'd1);
        wait_hit("t3_re4", 30);
        check("t3_instr4", External_Instr, memval(32'h04));
        wait_idle("t3_re4", 30);
        check("t3_q_empty", exp_addr_q.size(), 32'd0);

        // Flush coinciding with Mem_Ack.
        mem_wait = 0;
        step();
        External_PC = 32'h200;
        exp_addr_q.push_back(32'h200);
        exp_addr_q.push_back(32'h200);
        exp_addr_q.push_back(32'h204);
        exp_addr_q.push_back(32'h208);
        exp_addr_q.push_back(32'h20C);
        step();
        check("t4_req", {31'b0, Mem_Req}, 32'd1);
        check("t4_addr", Mem_Addr, 32'h200);
        Flush = 1'b1;
        gen   = 8'h22;
        #1;
        check("t4_flush_stall", {31'b0, InstrStall}, 32'd1);
        step();
        check("t4_idle", {31'b0, Mem_Req}, 32'd0);
        check("t4_still_stall", {31'b0, InstrStall}, 32'd1);
        Flush = 1'b0;
        wait_hit("t4_refetch", 20);
        check("t4_instr_new", External_Instr, memval(32'h200));
        wait_idle("t4", 20);
        check("t4_q_empty", exp_addr_q.size(), 32'd0);

        // Asynchronous reset in the middle of a fill.
        mem_wait = 3;
        step();
        External_PC = 32'h300;
        exp_addr_q.push_back(32'h300);
        exp_addr_q.push_back(32'h304);
        exp_addr_q.push_back(32'h308);
        exp_addr_q.push_back(32'h30C);
        step();
        check("t5_req_pre", {31'b0, Mem_Req}, 32'd1);
        #2;
        reset = 1'b0;
        #1;
        check("t5_rst_req", {31'b0, Mem_Req}, 32'd0);
        check("t5_rst_stall", {31'b0, InstrStall}, 32'd1);
        check("t5_rst_instr", External_Instr, NOP);
        step();
        step();
        reset = 1'b1;
        wait_hit("t5_refetch", 30);
        check("t5_instr", External_Instr, memval(32'h300));
        wait_idle("t5", 30);
        check("t5_q_empty", exp_addr_q.size(), 32'd0);

        // Misaligned PC maps onto its containing word.
        mem_wait = 1;
        step();
        External_PC = 32'h6;
        exp_addr_q.push_back(32'h04);
        exp_addr_q.push_back(32'h08);
        exp_addr_q.push_back(32'h0C);
        exp_addr_q.push_back(32'h00);
        #1;
        check("t6_miss", {31'b0, InstrStall}, 32'd1);
        wait_hit("t6", 20);
        check("t6_instr", External_Instr, memval(32'h04));
        External_PC = 32'h5;
        #1;
        check("t6_instr_pc5", External_Instr, memval(32'h04));
        wait_idle("t6", 20);
        check("t6_q_empty", exp_addr_q.size(), 32'd0);

        step();
        check("hs_violations", hs_violations, 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
